// File: rtl/debounce_botoes_pkg.sv
// Shared definitions for the two-button debounce front end:
// channel FSM state encoding and default timing parameters.
package debounce_botoes_pkg;

   typedef enum logic [1:0] {
      SOLTO       = 2'd0,
      CONF_PRESS  = 2'd1,
      PRESSIONADO = 2'd2,
      CONF_SOLTA  = 2'd3
   } estado_t;

   localparam int unsigned DEBOUNCE_CYCLES_DEF = 50000;
   localparam int unsigned CNT_W_DEF           = 16;

endpackage

// File: rtl/debounce_botoes_canal.sv
// One button channel: 2-FF synchroniser, stability counter and press/release FSM.
// evento_press is high for the single cycle in which a press is accepted.
module debounce_botoes_canal
   import debounce_botoes_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned CNT_W           = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic bruto,
   output logic evento_press
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_a;
   logic             sync_s;
   estado_t          estado;
   logic [CNT_W-1:0] cnt;

   // Two-stage synchroniser for the asynchronous raw input
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_a <= 1'b0;
         sync_s <= 1'b0;
      end else begin
         sync_a <= bruto;
         sync_s <= sync_a;
      end
   end

   // Reset lands in PRESSIONADO so a button held through reset is never reported
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         estado <= PRESSIONADO;
         cnt    <= '0;
      end else begin
         case (estado)
            SOLTO: begin
               if (sync_s) begin
                  estado <= CONF_PRESS;
                  cnt    <= '0;
               end
            end
            CONF_PRESS: begin
               if (!sync_s) begin
                  estado <= SOLTO;
                  cnt    <= '0;
               end else if (cnt == CNT_MAX) begin
                  estado <= PRESSIONADO;
                  cnt    <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            PRESSIONADO: begin
               if (!sync_s) begin
                  estado <= CONF_SOLTA;
                  cnt    <= '0;
               end
            end
            CONF_SOLTA: begin
               if (sync_s) begin
                  estado <= PRESSIONADO;
                  cnt    <= '0;
               end else if (cnt == CNT_MAX) begin
                  estado <= SOLTO;
                  cnt    <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               estado <= PRESSIONADO;
               cnt    <= '0;
            end
         endcase
      end
   end

   // Same-cycle event so the top can register the output pulse on this very edge
   assign evento_press = (estado == CONF_PRESS) && sync_s && (cnt == CNT_MAX);

endmodule

// File: rtl/debounce_botoes.sv
// Two-button front end: debounces both raw inputs and serialises the press pulses
// with fixed priority to button 1, so both outputs are never high together.
module debounce_botoes
   import debounce_botoes_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned CNT_W           = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic BotaoBruto1,
   input  logic BotaoBruto2,
   output logic SinalBotao1,
   output logic SinalBotao2
);

   logic ev1;
   logic ev2;
   logic pend1;
   logic pend2;
   logic req1;
   logic req2;
   logic grant1;
   logic grant2;

   debounce_botoes_canal #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_canal1 (
      .clk          (clk),
      .rst_n        (rst_n),
      .bruto        (BotaoBruto1),
      .evento_press (ev1)
   );

   debounce_botoes_canal #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_canal2 (
      .clk          (clk),
      .rst_n        (rst_n),
      .bruto        (BotaoBruto2),
      .evento_press (ev2)
   );

   // Fixed-priority arbiter over fresh events and parked ones
   always_comb begin
      req1   = pend1 | ev1;
      req2   = pend2 | ev2;
      grant1 = req1;
      grant2 = req2 & ~req1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend1       <= 1'b0;
         pend2       <= 1'b0;
         SinalBotao1 <= 1'b0;
         SinalBotao2 <= 1'b0;
      end else begin
         pend1       <= req1 & ~grant1;
         pend2       <= req2 & ~grant2;
         SinalBotao1 <= grant1;
         SinalBotao2 <= grant2;
      end
   end

endmodule

// File: tb/tb_debounce_botoes.sv
// Scoreboard bench for debounce_botoes with DEBOUNCE_CYCLES=4: stimulus queues the
// expected (channel, cycle) of every pulse, a negedge monitor pops and compares.
module tb_debounce_botoes;

   localparam int unsigned DC = 4;
   localparam int unsigned CW = 3;
   // Edge e(DC+2) registers the pulse; sampled cyc at the following negedge is drive cyc + DC+3
   localparam int LAT = int'(DC) + 3;

   typedef struct {
      int ch;
      int cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic b1;
   logic b2;
   logic s1;
   logic s2;

   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   debounce_botoes #(
      .DEBOUNCE_CYCLES (DC),
      .CNT_W           (CW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .BotaoBruto1 (b1),
      .BotaoBruto2 (b2),
      .SinalBotao1 (s1),
      .SinalBotao2 (s2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input int ch, input int off);
      exp_t e;
      e.ch  = ch;
      e.cyc = cyc + off;
      sb.push_back(e);
   endtask

   task automatic chk_idle(input string name);
      checks++;
      if (s1 !== 1'b0 || s2 !== 1'b0) begin
         errors++;
         $display("FAIL %s: outputs s1=%b s2=%b, required 0 0 (cyc %0d)", name, s1, s2, cyc);
      end
   endtask

   task automatic chk_pulse(input int ch);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL unexpected_pulse: SinalBotao%0d high at cyc %0d, no pulse required", ch, cyc);
      end else begin
         e = sb.pop_front();
         if (e.ch != ch || e.cyc != cyc) begin
            errors++;
            $display("FAIL pulse_match: got ch %0d at cyc %0d, required ch %0d at cyc %0d",
                     ch, cyc, e.ch, e.cyc);
         end
      end
   endtask

   // Monitor: mutual exclusion every cycle, and every pulse against the scoreboard
   always @(negedge clk) begin
      checks++;
      if (s1 === 1'b1 && s2 === 1'b1) begin
         errors++;
         $display("FAIL mutex: s1=%b s2=%b both high at cyc %0d, required never both", s1, s2, cyc);
      end
      if (s1 === 1'b1) chk_pulse(1);
      if (s2 === 1'b1) chk_pulse(2);
   end

   initial begin
      rst_n = 1'b0;
      b1    = 1'b0;
      b2    = 1'b0;

      // 1: reset state, then a clean hold of button 1
      wait_n(3);
      chk_idle("reset_state");
      rst_n = 1'b1;
      wait_n(10);
      b1 = 1'b1;
      push(1, LAT);
      wait_n(20);
      b1 = 1'b0;
      wait_n(12);

      // 2: button 2 bounces 1,0,1,1,0 then settles high
      b2 = 1'b1; wait_n(1);
      b2 = 1'b0; wait_n(1);
      b2 = 1'b1; wait_n(1);
      b2 = 1'b1; wait_n(1);
      b2 = 1'b0; wait_n(1);
      b2 = 1'b1;
      push(2, LAT);
      wait_n(15);
      b2 = 1'b0;
      wait_n(12);

      // 3: simultaneous presses, button 2 deferred by one cycle
      b1 = 1'b1;
      b2 = 1'b1;
      push(1, LAT);
      push(2, LAT + 1);
      wait_n(15);
      b1 = 1'b0;
      b2 = 1'b0;
      wait_n(12);

      // 4: button held through reset gives no pulse; a later re-press does
      b1    = 1'b1;
      rst_n = 1'b0;
      wait_n(1);
      chk_idle("reset_held_button");
      wait_n(2);
      rst_n = 1'b1;
      wait_n(30);
      b1 = 1'b0;
      wait_n(10);
      b1 = 1'b1;
      push(1, LAT);
      wait_n(15);

      // 5: release with a 2-cycle bounce, then press again after 8 low cycles
      b1 = 1'b0; wait_n(1);
      b1 = 1'b1; wait_n(1);
      b1 = 1'b0; wait_n(8);
      b1 = 1'b1;
      push(1, LAT);
      wait_n(12);
      b1 = 1'b0;
      wait_n(12);

      // 6: reset while channel 1 is mid-confirmation (cnt=2)
      b1 = 1'b1;
      wait_n(5);
      rst_n = 1'b0;
      wait_n(1);
      chk_idle("reset_mid_press");
      wait_n(1);
      chk_idle("reset_mid_press_held");
      rst_n = 1'b1;
      wait_n(20);
      b1 = 1'b0;
      wait_n(20);

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL missing_pulses: %0d expected pulses never seen, required 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
